// File: rtl/musa_pkg.sv
// Shared core definitions: fetch state encoding and the reset fetch address.
package musa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/PCAdder.sv
// Sequential-PC incrementer: next instruction address, wrapping modulo 2^32.
module PCAdder (
    input  logic [31:0] pcOld,
    output logic [31:0] pcNew
);

    assign pcNew = pcOld + 32'd4;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem reads and registers the
// fetched word plus its PC+4 for decode, with branch/jump redirection.
module pc_fetch_unit
    import musa_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        jump,
    input  logic [31:0] jumpTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] instrOut,
    output logic [31:0] pcOut,
    output logic        instrValid
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_plus4, redirect_pc;
    logic         redirect, capture, consume;

    PCAdder u_pc_adder (
        .pcOld (pc),
        .pcNew (pc_plus4)
    );

    assign imemAddr = pc;

    always_comb begin
        redirect    = branchTaken | jump;
        // Branch wins over jump; targets are forced word-aligned.
        redirect_pc = (branchTaken ? branchTarget : jumpTarget) & ~32'h0000_0003;
        consume     = instrValid && !stall;
        imemReq     = (state == FETCH) && !(instrValid && stall) && !redirect;
        capture     = imemReq && imemAck;

        state_next = state;
        if (redirect) begin
            state_next = FETCH;
        end else begin
            case (state)
                IDLE:    state_next = FETCH;
                FETCH:   if (capture && stall) state_next = HOLD;
                HOLD:    if (consume) state_next = FETCH;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            instrOut   <= '0;
            pcOut      <= '0;
            instrValid <= 1'b0;
        end else if (redirect) begin
            pc         <= redirect_pc;
            instrValid <= 1'b0;
        end else if (capture) begin
            instrOut   <= imemData;
            pcOut      <= pc_plus4;
            pc         <= pc_plus4;
            instrValid <= 1'b1;
        end else if (consume) begin
            instrValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: per-cycle vector table fed through
// an expectation queue, plus a hand-written asynchronous reset sequence.
module tb_pc_fetch_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        stall, branchTaken, jump, imemAck;
    logic [31:0] branchTarget, jumpTarget, imemData;
    logic        imemReq, instrValid;
    logic [31:0] imemAddr, instrOut, pcOut;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] brt;
        logic        jmp;
        logic [31:0] jt;
        logic        ack;
        logic [31:0] data;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .jump         (jump),
        .jumpTarget   (jumpTarget),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemAck      (imemAck),
        .imemData     (imemData),
        .instrOut     (instrOut),
        .pcOut        (pcOut),
        .instrValid   (instrValid)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt, input logic a,
                                input logic [31:0] d, input logic rq, input logic [31:0] ad,
                                input logic v, input logic [31:0] ins, input logic [31:0] p);
        vec_t r;
        r.stall = s; r.br = b; r.brt = bt; r.jmp = j; r.jt = jt; r.ack = a; r.data = d;
        r.req = rq; r.addr = ad; r.valid = v; r.instr = ins; r.pc = p;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check during the cycle, then advance past the edge.
    task automatic step(input int idx, input vec_t v);
        vec_t e;
        stall = v.stall; branchTaken = v.br; branchTarget = v.brt;
        jump = v.jmp; jumpTarget = v.jt; imemAck = v.ack; imemData = v.data;
        sb.push_back(v);
        @(negedge clock);
        if (sb.size() == 0) begin
            chk($sformatf("v%0d_scoreboard_empty", idx), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d_imemReq", idx),    {31'd0, imemReq},    {31'd0, e.req});
            chk($sformatf("v%0d_imemAddr", idx),   imemAddr,            e.addr);
            chk($sformatf("v%0d_instrValid", idx), {31'd0, instrValid}, {31'd0, e.valid});
            chk($sformatf("v%0d_instrOut", idx),   instrOut,            e.instr);
            chk($sformatf("v%0d_pcOut", idx),      pcOut,               e.pc);
        end
        @(posedge clock);
        #1;
    endtask

    localparam logic [31:0] X  = 32'hDEAD_BEEF;
    localparam logic [31:0] LW = 32'h8C22_0004;

    initial begin
        reset = 1'b1;
        stall = 0; branchTaken = 0; jump = 0; imemAck = 1;
        branchTarget = '0; jumpTarget = '0; imemData = '0;

        //            stl br  brt         jmp jt          ack data          req addr          vld instr         pcOut
        vecs.push_back(mk(0, 0, 0,           0, 0,           1, 32'hA000_0000, 0, 32'h0,         0, 32'h0,         32'h0));   // IDLE
        vecs.push_back(mk(0, 0, 0,           0, 0,           1, 32'hA000_0001, 1, 32'h0,         0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0,           0, 0,           1, 32'hA000_0002, 1, 32'h4,         1, 32'hA000_0001, 32'h4));
        vecs.push_back(mk(0, 0, 0,           0, 0,           1, 32'hA000_0003, 1, 32'h8,         1, 32'hA000_0002, 32'h8));
        vecs.push_back(mk(0, 0, 0,           0, 0,           0, X,             1, 32'hC,         1, 32'hA000_0003, 32'hC));
        vecs.push_back(mk(1, 0, 0,           0, 0,           1, LW,            1, 32'hC,         0, 32'hA000_0003, 32'hC));   // capture under stall
        vecs.push_back(mk(1, 0, 0,           0, 0,           1, X,             0, 32'h10,        1, LW,            32'h10));
        vecs.push_back(mk(1, 0, 0,           0, 0,           1, X,             0, 32'h10,        1, LW,            32'h10));
        vecs.push_back(mk(1, 0, 0,           0, 0,           1, X,             0, 32'h10,        1, LW,            32'h10));
        vecs.push_back(mk(0, 0, 0,           0, 0,           1, X,             0, 32'h10,        1, LW,            32'h10));   // HOLD consumed
        vecs.push_back(mk(0, 0, 0,           0, 0,           1, 32'hB000_0000, 1, 32'h10,        0, LW,            32'h10));
        vecs.push_back(mk(0, 1, 32'h103,     0, 0,           1, X,             0, 32'h14,        1, 32'hB000_0000, 32'h14));  // branch + ack
        vecs.push_back(mk(0, 0, 0,           0, 0,           0, X,             1, 32'h100,       0, 32'hB000_0000, 32'h14));
        vecs.push_back(mk(0, 1, 32'h40,      1, 32'h80,      0, X,             0, 32'h100,       0, 32'hB000_0000, 32'h14));  // branch beats jump
        vecs.push_back(mk(0, 0, 0,           0, 0,           0, X,             1, 32'h40,        0, 32'hB000_0000, 32'h14));
        vecs.push_back(mk(0, 0, 0,           1, 32'hFFFF_FFFE, 0, X,           0, 32'h40,        0, 32'hB000_0000, 32'h14));
        vecs.push_back(mk(0, 0, 0,           0, 0,           1, 32'hC000_0000, 1, 32'hFFFF_FFFC, 0, 32'hB000_0000, 32'h14));  // wrap
        vecs.push_back(mk(0, 0, 0,           0, 0,           0, X,             1, 32'h0,         1, 32'hC000_0000, 32'h0));
        vecs.push_back(mk(0, 0, 0,           0, 0,           0, X,             1, 32'h0,         0, 32'hC000_0000, 32'h0));
        vecs.push_back(mk(0, 0, 0,           1, 32'h200,     0, X,             0, 32'h0,         0, 32'hC000_0000, 32'h0));
        vecs.push_back(mk(0, 0, 0,           0, 0,           0, X,             1, 32'h200,       0, 32'hC000_0000, 32'h0));   // pending request

        #2;
        chk("rst_imemReq",    {31'd0, imemReq},    32'd0);
        chk("rst_instrValid", {31'd0, instrValid}, 32'd0);
        chk("rst_imemAddr",   imemAddr,            32'h0);
        chk("rst_instrOut",   instrOut,            32'h0);
        chk("rst_pcOut",      pcOut,               32'h0);
        @(posedge clock);
        #3;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) step(i, vecs[i]);

        // Asynchronous reset while a request to 0x200 is pending.
        chk("pre_reset_req", {31'd0, imemReq}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_imemReq",    {31'd0, imemReq},    32'd0);
        chk("async_rst_imemAddr",   imemAddr,            32'h0);
        chk("async_rst_instrValid", {31'd0, instrValid}, 32'd0);
        chk("async_rst_instrOut",   instrOut,            32'h0);
        chk("async_rst_pcOut",      pcOut,               32'h0);
        imemAck = 1'b1;
        @(posedge clock);
        #1;
        chk("held_rst_imemReq", {31'd0, imemReq}, 32'd0);
        #2;
        reset = 1'b0;
        step(100, mk(0, 0, 0, 0, 0, 1, 32'hE000_0000, 0, 32'h0, 0, 32'h0, 32'h0));
        step(101, mk(0, 0, 0, 0, 0, 1, 32'hE000_0001, 1, 32'h0, 0, 32'h0, 32'h0));
        step(102, mk(0, 0, 0, 0, 0, 0, X,             1, 32'h4, 1, 32'hE000_0001, 32'h4));

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
